// File: rtl/reg_file_wb.sv
// Write-back register file: one write port, two bypassed decode read ports,
// and one committed-value debug port. Index 0 always reads as zero.
module reg_file_wb #(
    parameter int size   = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [size-1:0]   write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] dbg_reg,
    output logic [size-1:0]   read_data1,
    output logic [size-1:0]   read_data2,
    output logic [size-1:0]   dbg_data
);

    localparam int NREG = 1 << ADDR_W;

    logic [size-1:0] regs [NREG];
    logic            wr_en;

    // Writes to index 0 are dropped so it stays cleared from reset onward.
    assign wr_en = RegWrite && !reset && (write_reg != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[write_reg] <= write_data;
        end
    end

    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        dbg_data   = '0;

        if (read_reg1 != '0) begin
            if (wr_en && (write_reg == read_reg1)) begin
                read_data1 = write_data;
            end else begin
                read_data1 = regs[read_reg1];
            end
        end

        if (read_reg2 != '0) begin
            if (wr_en && (write_reg == read_reg2)) begin
                read_data2 = write_data;
            end else begin
                read_data2 = regs[read_reg2];
            end
        end

        // Display path shows committed state only.
        if (dbg_reg != '0) begin
            dbg_data = regs[dbg_reg];
        end
    end

endmodule
